// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// Optional watchdog build macro: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_e;

  function automatic int onehot2idx(
    input logic [31:0] oh
  );
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bridge-side mem port of the arbiter.
// master = arbiter, slave = AXI memory bridge.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ready_i;

  modport master (
    output mem_ce_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_data_i,
    input  mem_ready_i
  );

  modport slave (
    input  mem_ce_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_data_i,
    output mem_ready_i
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (!found && req[i] &&
            i == (int'(ptr) + k) % N) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
    valid = |req;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one bridge mem port.
// Define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_ce_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [DATA_W-1:0]         req_data_o,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        req_err_o,
  output logic [NUM_REQ-1:0]        grant_o,
  mem_port_arbiter_if.master        mem
);

  localparam int PW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     nxt_ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic              pick_vld;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  int                owner;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req   (req_ce_i),
    .ptr   (rr_ptr),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_gnt[i]) begin
        sel_we   = req_we_i[i];
        sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_data = req_data_i[i*DATA_W +: DATA_W];
      end
  end

  // Finished owner drops to lowest priority.
  always_comb begin
    owner   = onehot2idx(32'(grant_o));
    nxt_ptr = PW'((owner + 1) % NUM_REQ);
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0]        wd_cnt;
  logic [NUM_REQ-1:0] err_q;
  assign req_err_o = err_q;
`else
  assign req_err_o = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_o        <= '0;
      req_ready_o    <= '0;
      req_data_o     <= '0;
      mem.mem_ce_o   <= 1'b0;
      mem.mem_we_o   <= 1'b0;
      mem.mem_addr_o <= '0;
      mem.mem_data_o <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wd_cnt         <= '0;
      err_q          <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_o        <= pick_gnt;
            mem.mem_ce_o   <= 1'b1;
            mem.mem_we_o   <= sel_we;
            mem.mem_addr_o <= sel_addr;
            mem.mem_data_o <= sel_data;
            state          <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
          end
        end
        BUSY: begin
          if (mem.mem_ready_i) begin
            mem.mem_ce_o <= 1'b0;
            req_data_o   <= mem.mem_we_o ?
                            '0 : mem.mem_data_i;
            req_ready_o  <= grant_o;
            rr_ptr       <= nxt_ptr;
            state        <= DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wd_cnt ==
                   16'(TIMEOUT_CYC - 1)) begin
            mem.mem_ce_o <= 1'b0;
            req_data_o   <= '0;
            req_ready_o  <= grant_o;
            err_q        <= grant_o;
            rr_ptr       <= nxt_ptr;
            state        <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          req_ready_o    <= '0;
          grant_o        <= '0;
          req_data_o     <= '0;
          mem.mem_we_o   <= 1'b0;
          mem.mem_addr_o <= '0;
          mem.mem_data_o <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
          err_q          <= '0;
`endif
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
